// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word type, fetch FSM state encoding and PC step
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int PC_STEP = 4;

  // Legacy-compatible raw encodings, also used as the enum values
  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_MEM    = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  typedef enum logic [1:0] {
    BOOT   = ST_BOOT,
    FETCH  = ST_FETCH,
    MEM    = ST_MEM,
    HALTED = ST_HALTED
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next PC priority mux: jump, then taken branch, then sequential
module next_pc_sel #(
  parameter int WORD_W  = 32,
  parameter int PC_STEP = cpu_types_pkg::PC_STEP
) (
  input  logic [WORD_W-1:0] pc,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  output logic [WORD_W-1:0] target
);
  import cpu_types_pkg::*;

  // Jump wins over branch; sequential add wraps naturally at WORD_W bits
  always_comb begin
    target = pc + WORD_W'(PC_STEP);
    if (jump) begin
      target = jump_target;
    end else if (branch_taken) begin
      target = branch_target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/memory-port sequencer; FETCH_PERF_EN adds instr/stall counters
module fetch_sequencer #(
  parameter int WORD_W     = 32,
  parameter int PC_STEP    = cpu_types_pkg::PC_STEP,
  parameter int WAIT_LIMIT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] pc,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmem_req,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_target,
  input  logic              halt_in,
  output logic              pcWEN,
  output logic [WORD_W-1:0] pc_next,
  output logic              iREN,
  output logic              dmem_en,
  output logic              halt,
  output logic              timeout
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       instr_count,
  output logic [31:0]       stall_count
`endif
);
  import cpu_types_pkg::*;

  localparam logic [31:0] LIMIT = 32'(WAIT_LIMIT);

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [WORD_W-1:0] redirect;
  logic [WORD_W-1:0] target;
  logic [31:0]       wait_cnt;
  logic              fetch_hit;
  logic              halt_dec;
  logic              take_mem;
  logic              waiting;

  assign fetch_hit = (state == FETCH) && ihit;
  assign halt_dec  = fetch_hit && halt_in;
  assign take_mem  = fetch_hit && !halt_in && dmem_req;
  assign waiting   = ((state == FETCH) && !ihit) || ((state == MEM) && !dhit);
  assign halt      = (state == HALTED);

  next_pc_sel #(
    .WORD_W (WORD_W),
    .PC_STEP(PC_STEP)
  ) u_next_pc_sel (
    .pc           (pc),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .target       (target)
  );

  // Request outputs, PC write and next-state decode; pc_next holds pc when idle
  always_comb begin
    state_nx = state;
    pcWEN    = 1'b0;
    pc_next  = pc;
    iREN     = 1'b0;
    dmem_en  = 1'b0;
    case (state)
      BOOT: state_nx = FETCH;
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          if (halt_in) begin
            state_nx = HALTED;
          end else if (dmem_req) begin
            state_nx = MEM;
          end else begin
            pcWEN   = 1'b1;
            pc_next = target;
          end
        end
      end
      MEM: begin
        dmem_en = 1'b1;
        if (dhit) begin
          pcWEN    = 1'b1;
          pc_next  = redirect;
          state_nx = FETCH;
        end
      end
      HALTED: state_nx = HALTED;
      default: state_nx = BOOT;
    endcase
  end

  // State and the PC redirect captured at decode of a load/store
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= BOOT;
      redirect <= '0;
    end else begin
      state <= state_nx;
      if (take_mem) begin
        redirect <= target;
      end
    end
  end

  // Consecutive-wait counter with sticky timeout; sequencing is unaffected
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (waiting) begin
      if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
      if ((LIMIT != 32'd0) && ((wait_cnt + 32'd1) >= LIMIT)) begin
        timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef FETCH_PERF_EN
  // Retired-instruction and stall counters, free-running with wrap
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (pcWEN || halt_dec) begin
        instr_count <= instr_count + 32'd1;
      end
      if (waiting) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc;
  logic        ihit;
  logic        dhit;
  logic        dmem_req;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt_in;
  logic        pcWEN;
  logic [31:0] pc_next;
  logic        iREN;
  logic        dmem_en;
  logic        halt;
  logic        timeout;
`ifdef FETCH_PERF_EN
  logic [31:0] instr_count;
  logic [31:0] stall_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  fetch_sequencer #(
    .WORD_W    (32),
    .PC_STEP   (4),
    .WAIT_LIMIT(4)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .pc           (pc),
    .ihit         (ihit),
    .dhit         (dhit),
    .dmem_req     (dmem_req),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt_in      (halt_in),
    .pcWEN        (pcWEN),
    .pc_next      (pc_next),
    .iREN         (iREN),
    .dmem_en      (dmem_en),
    .halt         (halt),
    .timeout      (timeout)
`ifdef FETCH_PERF_EN
    ,
    .instr_count  (instr_count),
    .stall_count  (stall_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every pcWEN pulse consumes one expected target; otherwise pc_next must equal pc
  always @(negedge CLK) begin
    if (nRST === 1'b1 && pcWEN === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pcwen: got pcWEN=1 pc_next=%h expected no write at %0t", pc_next, $time);
      end else begin
        chk("pc_next", pc_next, exp_q.pop_front());
      end
    end else begin
      chk("pc_next_hold", pc_next, pc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    pc = 32'h0; ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
    halt_in = 1'b0; nRST = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst_pcwen", pcWEN, 0);
    chk("rst_iren", iREN, 0);
    chk("rst_dmem_en", dmem_en, 0);
    chk("rst_halt", halt, 0);
    chk("rst_timeout", timeout, 0);

    // Release: one BOOT cycle, then back-to-back sequential fetches
    tick(); nRST = 1'b1;
    @(negedge CLK); chk("boot_iren", iREN, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4);
      exp_q.push_back(32'(i * 4 + 4));
      @(negedge CLK); chk("seq_iren", iREN, 1);
      tick();
    end

    // Load/store with taken branch: redirect applied on the dhit cycle
    pc = 32'h40; dmem_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    @(negedge CLK); chk("ls_fetch_iren", iREN, 1); chk("ls_fetch_dmem_en", dmem_en, 0);
    tick();
    dmem_req = 1'b0; branch_taken = 1'b0; jump = 1'b1; jump_target = 32'hDEAD0000;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        dhit = 1'b1;
        exp_q.push_back(32'h100);
      end
      @(negedge CLK); chk("mem_iren", iREN, 0); chk("mem_dmem_en", dmem_en, 1);
      tick();
    end
    ihit = 1'b0; jump = 1'b0; dhit = 1'b0; pc = 32'h100;
    @(negedge CLK); chk("post_mem_iren", iREN, 1); chk("post_mem_dmem_en", dmem_en, 0);
    tick();

    // Jump beats branch, branch alone, sequential wrap
    pc = 32'h104; ihit = 1'b1; jump = 1'b1; jump_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300;
    exp_q.push_back(32'h200); @(negedge CLK); tick();
    pc = 32'h200; jump = 1'b0;
    exp_q.push_back(32'h300); @(negedge CLK); tick();
    pc = 32'hFFFFFFFC; branch_taken = 1'b0;
    exp_q.push_back(32'h0); @(negedge CLK); tick();

    // Timeout after the fourth consecutive wait cycle, sticky afterwards
    ihit = 1'b0; pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); chk("timeout_before_limit", timeout, 0);
      tick();
    end
    @(negedge CLK); chk("timeout_set", timeout, 1); chk("timeout_still_fetching", iREN, 1);
    tick();
    ihit = 1'b1; exp_q.push_back(32'h4); @(negedge CLK); tick();
    ihit = 1'b0;
    @(negedge CLK); chk("timeout_sticky", timeout, 1);
    tick();

    // Halt has priority over load/store and jump
    pc = 32'h20; ihit = 1'b1; halt_in = 1'b1; dmem_req = 1'b1; jump = 1'b1; jump_target = 32'h999;
    @(negedge CLK); chk("halt_decode_halt", halt, 0); chk("halt_decode_dmem_en", dmem_en, 0);
    tick();
    halt_in = 1'b0; dmem_req = 1'b0; jump = 1'b0;
    for (int k = 0; k < 20; k++) begin
      dhit = k[0];
      @(negedge CLK);
      chk("halted_iren", iREN, 0); chk("halted_dmem_en", dmem_en, 0); chk("halted_halt", halt, 1);
      tick();
    end

    // Reset out of HALTED, enter MEM, then reset asynchronously mid-MEM
    ihit = 1'b0; dhit = 1'b0; nRST = 1'b0;
    tick(); nRST = 1'b1;
    tick();
    pc = 32'h50; ihit = 1'b1; dmem_req = 1'b1;
    @(negedge CLK); chk("rm_fetch_iren", iREN, 1);
    tick();
    ihit = 1'b0; dmem_req = 1'b0;
    @(negedge CLK); chk("rm_mem_dmem_en", dmem_en, 1);
    @(posedge CLK); #2;
    nRST = 1'b0; dhit = 1'b1;
    #1;
    chk("rm_async_dmem_en", dmem_en, 0);
    chk("rm_async_iren", iREN, 0);
    chk("rm_async_pcwen", pcWEN, 0);
    chk("rm_async_timeout", timeout, 0);
    chk("rm_async_halt", halt, 0);
    tick(); nRST = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); chk("rm_refetch_iren", iREN, 1);
      tick();
    end
    dhit = 1'b0; pc = 32'h60; ihit = 1'b1;
    exp_q.push_back(32'h64); @(negedge CLK); tick();
    ihit = 1'b0;
    @(negedge CLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
